// File: rtl/pong_pkg.sv
// Shared VGA timing constants, ball playfield limits and enum types for the pong ball datapath.
package pong_pkg;

  localparam int H         = 640;
  localparam int HFP       = 16;
  localparam int HS        = 40;
  localparam int HBP       = 128;
  localparam int V         = 480;
  localparam int VFP       = 10;
  localparam int VS        = 2;
  localparam int VBP       = 29;
  localparam int BALL_SIZE = 16;

  // Limits are in raw counter coordinates, origin at the start of sync.
  localparam logic [9:0] X_MIN = 10'(HS + HBP);
  localparam logic [9:0] X_MAX = 10'(HS + HBP + H - BALL_SIZE);
  localparam logic [9:0] Y_MIN = 10'(VS + VBP);
  localparam logic [9:0] Y_MAX = 10'(VS + VBP + V - BALL_SIZE);
  localparam logic [9:0] X_C   = 10'(HS + HBP + (H - BALL_SIZE) / 2);
  localparam logic [9:0] Y_C   = 10'(VS + VBP + (V - BALL_SIZE) / 2);

  // DIR_POS is right (x) or down (y).
  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;
  typedef enum logic {ST_SERVE = 1'b0, ST_MOVE = 1'b1} state_t;

endpackage

// File: rtl/pong_axis_step.sv
// One-axis clamp/reflect step: advances pos by speed, pins it to min/max and flips dir on a hit.
module pong_axis_step
  import pong_pkg::*;
(
  input  logic [9:0] i_pos,
  input  logic       i_dir,
  input  logic [3:0] i_speed,
  input  logic [9:0] i_min,
  input  logic [9:0] i_max,
  output logic [9:0] o_pos,
  output logic       o_dir,
  output logic       o_hit
);

  logic [10:0] w_fwd;
  logic [10:0] w_lo_lim;

  always_comb begin
    w_fwd    = {1'b0, i_pos} + {7'd0, i_speed};
    w_lo_lim = {1'b0, i_min} + {7'd0, i_speed};
    o_pos    = i_pos;
    o_dir    = i_dir;
    o_hit    = 1'b0;
    if (i_dir == DIR_NEG) begin
      // Compare before subtracting so the position can never wrap below min.
      if ({1'b0, i_pos} <= w_lo_lim) begin
        o_pos = i_min;
        o_dir = DIR_POS;
        o_hit = 1'b1;
      end else begin
        o_pos = i_pos - {6'd0, i_speed};
      end
    end else begin
      if (w_fwd >= {1'b0, i_max}) begin
        o_pos = i_max;
        o_dir = DIR_NEG;
        o_hit = 1'b1;
      end else begin
        o_pos = w_fwd[9:0];
      end
    end
  end

endmodule

// File: rtl/pong_ball_motion.sv
// Ball position/direction per video frame with serve hold and wall bounce.
// Optional speed ramp on bounces: define PONG_BALL_SPEED_RAMP_EN.
module pong_ball_motion
  import pong_pkg::*;
#(
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
`ifdef PONG_BALL_SPEED_RAMP_EN
  ,
  parameter int SPEED_MAX    = 8,
  parameter int RAMP_BOUNCES = 4
`endif
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       vga_vs,
  input  logic       enable,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] ball_speed,
  output logic       bounce,
  output logic       state_move
);

  localparam int SCW = $clog2(SERVE_FRAMES + 1);
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);

  logic           r_vs_q;
  logic [9:0]     r_x;
  logic [9:0]     r_y;
  dir_t           r_dir_x;
  dir_t           r_dir_y;
  state_t         r_state;
  logic [SCW-1:0] r_serve_cnt;
  logic           r_bounce;

  logic           w_tick;
  logic           w_adv;
  logic           w_move_step;
  state_t         w_state_nxt;
  logic [SCW-1:0] w_serve_nxt;
  logic [3:0]     w_speed;
  logic [9:0]     w_x_nxt;
  logic [9:0]     w_y_nxt;
  logic           w_dir_x_nxt;
  logic           w_dir_y_nxt;
  logic           w_hit_x;
  logic           w_hit_y;

  // One tick per frame on the falling edge of the active-low V-sync.
  assign w_tick = r_vs_q & ~vga_vs;
  assign w_adv  = w_tick & enable;

  always_comb begin
    w_state_nxt = r_state;
    w_serve_nxt = r_serve_cnt;
    w_move_step = 1'b0;
    case (r_state)
      ST_SERVE: begin
        if (w_adv) begin
          if (r_serve_cnt == SERVE_LAST) begin
            w_state_nxt = ST_MOVE;
          end else begin
            w_serve_nxt = r_serve_cnt + 1'b1;
          end
        end
      end
      ST_MOVE: begin
        w_move_step = w_adv;
      end
      default: begin
        w_state_nxt = ST_SERVE;
      end
    endcase
  end

  pong_axis_step u_step_x (
    .i_pos   (r_x),
    .i_dir   (r_dir_x),
    .i_speed (w_speed),
    .i_min   (X_MIN),
    .i_max   (X_MAX),
    .o_pos   (w_x_nxt),
    .o_dir   (w_dir_x_nxt),
    .o_hit   (w_hit_x)
  );

  pong_axis_step u_step_y (
    .i_pos   (r_y),
    .i_dir   (r_dir_y),
    .i_speed (w_speed),
    .i_min   (Y_MIN),
    .i_max   (Y_MAX),
    .o_pos   (w_y_nxt),
    .o_dir   (w_dir_y_nxt),
    .o_hit   (w_hit_y)
  );

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_vs_q      <= 1'b1;
      r_x         <= X_C;
      r_y         <= Y_C;
      r_dir_x     <= DIR_POS;
      r_dir_y     <= DIR_POS;
      r_state     <= ST_SERVE;
      r_serve_cnt <= '0;
      r_bounce    <= 1'b0;
    end else begin
      r_vs_q      <= vga_vs;
      r_state     <= w_state_nxt;
      r_serve_cnt <= w_serve_nxt;
      // A corner hit yields a single pulse since both axes share this flop.
      r_bounce    <= w_move_step & (w_hit_x | w_hit_y);
      if (w_move_step) begin
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        r_dir_x <= dir_t'(w_dir_x_nxt);
        r_dir_y <= dir_t'(w_dir_y_nxt);
      end
    end
  end

`ifdef PONG_BALL_SPEED_RAMP_EN
  localparam int BCW = $clog2(RAMP_BOUNCES + 1);
  localparam logic [BCW-1:0] RAMP_LAST = BCW'(RAMP_BOUNCES - 1);

  logic [3:0]     r_speed;
  logic [BCW-1:0] r_bounce_cnt;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_speed      <= 4'(SPEED);
      r_bounce_cnt <= '0;
    end else if (w_move_step && (w_hit_x || w_hit_y)) begin
      if (r_bounce_cnt == RAMP_LAST) begin
        r_bounce_cnt <= '0;
        if (r_speed < 4'(SPEED_MAX)) begin
          r_speed <= r_speed + 1'b1;
        end
      end else begin
        r_bounce_cnt <= r_bounce_cnt + 1'b1;
      end
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = 4'(SPEED);
`endif

  assign ball_x     = r_x;
  assign ball_y     = r_y;
  assign ball_speed = w_speed;
  assign bounce     = r_bounce;
  assign state_move = (r_state == ST_MOVE);

endmodule
